// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, FSM state type and shift-amount width shared by the ALU execution unit
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam int SHAMT_W = 5;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request (valid/ready, alu_control, op_a, op_b, req_rd) and response (valid/ready, result, rd) bus plus busy; master drives requests, slave is the unit
interface alu_exec_unit_if #(parameter int XLEN = 32, parameter int TAG_W = 5);
  logic req_valid, req_ready, resp_valid, resp_ready, busy;
  logic [3:0] alu_control;
  logic [XLEN-1:0] op_a, op_b, resp_result;
  logic [TAG_W-1:0] req_rd, resp_rd;
  modport master (
    output req_valid, alu_control, op_a, op_b, req_rd, resp_ready,
    input req_ready, resp_valid, resp_result, resp_rd, busy
  );
  modport slave (
    input req_valid, alu_control, op_a, op_b, req_rd, resp_ready,
    output req_ready, resp_valid, resp_result, resp_rd, busy
  );
endinterface

// File: rtl/alu_comb.sv
// alu_comb: single-cycle result from alu_control, op_a, op_b (shift and undefined codes yield 0)
module alu_comb import alu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result
);
  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_SLT:  result = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: result = XLEN'(op_a < op_b);
      ALU_XOR:  result = op_a ^ op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_AND:  result = op_a & op_b;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: FSM-sequenced ALU; ports clk, rst_n (async low) and bus (alu_exec_unit_if.slave); shifts iterate one bit per cycle
module alu_exec_unit import alu_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic clk,
  input logic rst_n,
  alu_exec_unit_if.slave bus
);
  state_t state, state_nxt;
  logic [XLEN-1:0] comb_res, shift_q, shift_nxt, result_q;
  logic [SHAMT_W-1:0] cnt_q, shamt;
  logic [TAG_W-1:0] rd_q;
  logic left_q, arith_q, accept, is_shift;
  alu_comb #(.XLEN(XLEN)) u_comb (
    .alu_control(bus.alu_control),
    .op_a(bus.op_a),
    .op_b(bus.op_b),
    .result(comb_res)
  );
  assign accept = bus.req_valid && bus.req_ready;
  assign shamt = bus.op_b[SHAMT_W-1:0];
  assign is_shift = bus.alu_control inside {ALU_SLL, ALU_SRL, ALU_SRA};
  assign shift_nxt = left_q ? {shift_q[XLEN-2:0], 1'b0} : {arith_q & shift_q[XLEN-1], shift_q[XLEN-1:1]};
  always_comb begin
    state_nxt = state;
    if (state == IDLE && accept) state_nxt = (is_shift && shamt != '0) ? SHIFT : DONE;
    if (state == SHIFT && cnt_q == SHAMT_W'(1)) state_nxt = DONE;
    if (state == DONE && bus.resp_ready) state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // result_q tracks the shifter each step so it holds the final value on entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q <= '0;
      left_q <= 1'b0;
      arith_q <= 1'b0;
      result_q <= '0;
      rd_q <= '0;
    end else if (accept) begin
      rd_q <= bus.req_rd;
      shift_q <= bus.op_a;
      cnt_q <= is_shift ? shamt : '0;
      left_q <= bus.alu_control == ALU_SLL;
      arith_q <= bus.alu_control == ALU_SRA;
      result_q <= is_shift ? bus.op_a : comb_res;
    end else if (state == SHIFT) begin
      shift_q <= shift_nxt;
      cnt_q <= cnt_q - SHAMT_W'(1);
      result_q <= shift_nxt;
    end
  end
  assign bus.req_ready = state == IDLE;
  assign bus.resp_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.resp_result = result_q;
  assign bus.resp_rd = rd_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  alu_exec_unit_if #(.XLEN(32), .TAG_W(5)) bus ();
  alu_exec_unit #(.XLEN(32), .TAG_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.alu_control = op;
    bus.op_a = a;
    bus.op_b = b;
    bus.req_rd = rd;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.op_a = $urandom;
    bus.op_b = $urandom;
    bus.req_rd = 5'($urandom);
  endtask
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!bus.resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(op, a, b, rd);
    wait_resp(lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, bus.resp_result, exp);
    check({tag, " rd"}, 32'(bus.resp_rd), 32'(rd));
    @(posedge clk);
    #1;
    check({tag, " idle busy/ready"}, {30'b0, bus.busy, bus.req_ready}, 32'b01);
  endtask
  initial begin
    int lat;
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    bus.alu_control = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.req_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready/valid/busy", {29'b0, bus.req_ready, bus.resp_valid, bus.busy}, 32'b100);
    check("reset result", bus.resp_result, 32'h0);
    check("reset rd", 32'(bus.resp_rd), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("add", ALU_ADD, 32'h5, 32'h3, 5'd7, 32'h8, 1);
    run_op("sub wrap", ALU_SUB, 32'h0, 32'h1, 5'd1, 32'hFFFF_FFFF, 1);
    run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd2, 32'h1, 1);
    run_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd3, 32'h0, 1);
    run_op("and", ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd4, 32'h00F0_1234, 1);
    run_op("or", ALU_OR, 32'h1200_0000, 32'h0034_0000, 5'd5, 32'h1234_0000, 1);
    run_op("undef", 4'b1100, 32'hDEAD_BEEF, 32'h1234_5678, 5'd6, 32'h0, 1);
    run_op("sra", ALU_SRA, 32'h8000_0000, 32'h0000_0024, 5'd8, 32'hF800_0000, 5);
    run_op("sll zero", ALU_SLL, 32'h1234_5678, 32'hFFFF_FFE0, 5'd10, 32'h1234_5678, 1);
    run_op("sll 4", ALU_SLL, 32'h0000_00F1, 32'h4, 5'd11, 32'h0000_0F10, 5);
    bus.resp_ready = 1'b0;
    issue(ALU_SRL, 32'h8000_0000, 32'd31, 5'd12);
    wait_resp(lat);
    check("srl31 latency", 32'(lat), 32'd32);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp result", bus.resp_result, 32'h1);
      check("bp rd", 32'(bus.resp_rd), 32'd12);
      check("bp valid/ready", {30'b0, bus.resp_valid, bus.req_ready}, 32'b10);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release", {29'b0, bus.resp_valid, bus.busy, bus.req_ready}, 32'b001);
    issue(ALU_SLL, 32'h0000_0001, 32'd20, 5'd9);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset ready/valid/busy", {29'b0, bus.req_ready, bus.resp_valid, bus.busy}, 32'b100);
    check("midreset result", bus.resp_result, 32'h0);
    check("midreset rd", 32'(bus.resp_rd), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op("xor", ALU_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd13, 32'hF00F_F00F, 1);
    repeat (25) @(posedge clk);
    #1;
    check("no stale shift", {30'b0, bus.resp_valid, bus.busy}, 32'b00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
